alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
Shares the single two-mode ALU (mode A logic unit, mode B floating-point unit) between two requesters. Arbitrates requests and registers the winner's operands onto the ALU inputs. Waits the ALU's fixed pipeline latency, then captures result, balance and equality bits and returns them to the winner with a one-cycle ack pulse. Sits between the ALU top and its client blocks.

Parameters:
RESULT_LAT, 3, cycles from ALU inputs being registered to ALU outputs valid; legal range 1..15.
CNT_W, 4, width of the wait counter; must hold RESULT_LAT-1.

Ports:
Clk  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
req  in  2  request per requester, bit i = requester i
mode_in  in  2  packed {r1,r0}; ALU mode, 0 = A (logic), 1 = B (float)
num1_in  in  10  packed {r1,r0} 5-bit operand 1
num2_in  in  10  packed {r1,r0} 5-bit operand 2
op_in  in  12  packed {r1,r0} 6-bit operator_mode
ack  out  2  one-cycle pulse to the granted requester; result valid in the same cycle
result  out  32  captured ALU output_num
res_balance  out  1  captured balanceBit
res_equality  out  1  captured equalityBit
busy  out  1  high in every state except IDLE
alu_mode  out  1  to ALU mode
alu_number1  out  5  to ALU number1
alu_number2  out  5  to ALU number2
alu_operator_mode  out  6  to ALU operator_mode
alu_reset  out  1  to ALU synchronous active-high reset
alu_output_num  in  32  from ALU
alu_balance  in  1  from ALU
alu_equality  in  1  from ALU

Behaviour:
- Reset (reset=0, asynchronous):
  - ack=0, result=0, res_balance=0, res_equality=0, busy=0.
  - All alu_* data outputs = 0; alu_reset=1.
  - state=IDLE, wait count=0, last_grant=1, so requester 0 wins first.
- alu_reset stays 1 for the first Clk edge after reset release, then 0. It clears the ALU's synchronous registers.
- All outputs are registered. State machine: IDLE -> WAIT -> DONE -> IDLE.
- IDLE: if any req bit is high at the edge:
  - Grant the winner.
  - Load its mode/num1/num2/op slices into the alu_* registers.
  - Set wait count=0 and go to WAIT.
  - With no request, stay in IDLE; alu_* keep their last values.
- Arbitration: 2-way round robin.
  - Single request wins.
  - If both request, the one not equal to last_grant wins.
  - last_grant updates at the grant.
- WAIT:
  - Count increments each edge.
  - At the edge where count==RESULT_LAT-1: capture alu_output_num, alu_balance and alu_equality into result/res_*; set ack[grant]=1; go to DONE.
- DONE: lasts one cycle with ack high, then returns to IDLE and ack returns to 0.
- Latency: req first sampled high in cycle 0 (IDLE) gives ALU inputs valid in cycle 1 and ack high in cycle 1+RESULT_LAT (cycle 4 at default).
- Requester protocol:
  - Hold req and operands stable until ack is seen.
  - Deassert req in the cycle after ack; otherwise it is treated as a new request.
  - Req and operand changes during WAIT/DONE are ignored; ALU inputs keep their latched values.
- result/res_* hold their value until the next capture.
- Reset asserted mid-WAIT or mid-DONE: the operation is aborted, no ack is issued, and all values return to their reset values.

Optional Feature:
ALU_SCHED_FIXED_PRIO_EN:
- Defined: requester 0 always wins simultaneous requests; last_grant is unused.
- Undefined: round robin as described above.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum {IDLE, WAIT, DONE}
  - constants NUM_W=5, OP_W=6, RES_W=32, REQ_N=2
- One sub-module: alu_rr_arbiter, a 2-way grant with last_grant pointer and the fixed-priority macro branch.
- Counter and capture logic stay in the top.

Test Plan:
1. Single op: after reset, req=2'b01 with mode=0, num1=3, num2=5, op=6'b000001; ALU model returns 32'h7 three cycles after inputs -> alu_* = 0/3/5/1 in cycle 1; ack=2'b01 in cycle 4; result=32'h7; busy high in cycles 1-4.
2. Contention: req=2'b11 right after reset -> r0 granted first, r1 granted in the IDLE after r0's ack. Both requesting again -> r0 (round robin). With ALU_SCHED_FIXED_PRIO_EN -> r0 every time.
3. Operand change during WAIT: r1 changes num1 from 9 to 17 in cycle 2 -> alu_number1 stays 9; result is from the 9 operation.
4. Reset mid-operation: reset low in cycle 2 of WAIT -> ack never pulses; result=0; alu_reset=1; next request after release completes normally.
5. Parameter sweep: RESULT_LAT=1 -> ack in cycle 2. RESULT_LAT=5 -> ack in cycle 6, with captured balance/equality matching the model (e.g. 1/0).

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the two-requester ALU scheduler.
package alu_sched_pkg;

  localparam int NUM_W = 5;
  localparam int OP_W  = 6;
  localparam int RES_W = 32;
  localparam int REQ_N = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Observation bundle: FSM state plus the round-robin pointer.
  typedef struct packed {
    state_t state;
    logic   last_grant;
  } dbg_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way arbiter with a last-grant pointer; ALU_SCHED_FIXED_PRIO_EN makes
// requester 0 win every tie instead of alternating.
module alu_rr_arbiter
  import alu_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic             grant_en,
  output logic             win,
  output logic             last_grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    win = 1'b0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
    win = ~req[0];
`else
    // On a tie the requester that did not win last time goes next.
    if (req == 2'b11) begin
      win = ~last_grant_q;
    end else begin
      win = ~req[0];
    end
`endif
    last_grant_d = last_grant_q;
    if (grant_en) begin
      last_grant_d = win;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one two-mode ALU between two requesters: arbitrate, register operands,
// wait RESULT_LAT cycles, capture and ack. Tie policy: ALU_SCHED_FIXED_PRIO_EN.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int RESULT_LAT = 3,
  parameter int CNT_W      = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic [REQ_N-1:0]       req,
  input  logic [REQ_N-1:0]       mode_in,
  input  logic [REQ_N*NUM_W-1:0] num1_in,
  input  logic [REQ_N*NUM_W-1:0] num2_in,
  input  logic [REQ_N*OP_W-1:0]  op_in,
  output logic [REQ_N-1:0]       ack,
  output logic [RES_W-1:0]       result,
  output logic                   res_balance,
  output logic                   res_equality,
  output logic                   busy,
  output logic                   alu_mode,
  output logic [NUM_W-1:0]       alu_number1,
  output logic [NUM_W-1:0]       alu_number2,
  output logic [OP_W-1:0]        alu_operator_mode,
  output logic                   alu_reset,
  input  logic [RES_W-1:0]       alu_output_num,
  input  logic                   alu_balance,
  input  logic                   alu_equality,
  output dbg_t                   dbg
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_q, grant_d;
  logic [REQ_N-1:0]   ack_q, ack_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               bal_q, bal_d;
  logic               eq_q, eq_d;
  logic               busy_q, busy_d;
  logic               mode_q, mode_d;
  logic [NUM_W-1:0]   n1_q, n1_d;
  logic [NUM_W-1:0]   n2_q, n2_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               alu_reset_q, alu_reset_d;
  logic               grant_en;
  logic               win;
  logic               last_grant;

  alu_rr_arbiter u_arb (
    .clk        (Clk),
    .rst_n      (reset),
    .req        (req),
    .grant_en   (grant_en),
    .win        (win),
    .last_grant (last_grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ack_d       = '0;
    result_d    = result_q;
    bal_d       = bal_q;
    eq_d        = eq_q;
    mode_d      = mode_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    op_d        = op_q;
    alu_reset_d = 1'b0;
    grant_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_en = 1'b1;
          grant_d  = win;
          mode_d   = win ? mode_in[1] : mode_in[0];
          n1_d     = win ? num1_in[2*NUM_W-1:NUM_W] : num1_in[NUM_W-1:0];
          n2_d     = win ? num2_in[2*NUM_W-1:NUM_W] : num2_in[NUM_W-1:0];
          op_d     = win ? op_in[2*OP_W-1:OP_W] : op_in[OP_W-1:0];
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // ALU output is valid on this edge; requester inputs are ignored here.
        if (cnt_q == CNT_W'(RESULT_LAT - 1)) begin
          result_d       = alu_output_num;
          bal_d          = alu_balance;
          eq_d           = alu_equality;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      ack_q       <= '0;
      result_q    <= '0;
      bal_q       <= 1'b0;
      eq_q        <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      n1_q        <= '0;
      n2_q        <= '0;
      op_q        <= '0;
      alu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      result_q    <= result_d;
      bal_q       <= bal_d;
      eq_q        <= eq_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      op_q        <= op_d;
      alu_reset_q <= alu_reset_d;
    end
  end

  assign ack               = ack_q;
  assign result            = result_q;
  assign res_balance       = bal_q;
  assign res_equality      = eq_q;
  assign busy              = busy_q;
  assign alu_mode          = mode_q;
  assign alu_number1       = n1_q;
  assign alu_number2       = n2_q;
  assign alu_operator_mode = op_q;
  assign alu_reset         = alu_reset_q;
  assign dbg               = '{state: state_q, last_grant: last_grant};

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler: three instances (RESULT_LAT 3, 1, 5)
// each driving a behavioural pipelined ALU model.
module tb_alu_req_scheduler;
  import alu_sched_pkg::*;

  localparam int N_INST = 3;
  localparam int EW     = 38;

  logic Clk   = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0]  req_a    [N_INST];
  logic [1:0]  mode_a   [N_INST];
  logic [9:0]  num1_a   [N_INST];
  logic [9:0]  num2_a   [N_INST];
  logic [11:0] op_a     [N_INST];
  logic [1:0]  ack_a    [N_INST];
  logic [31:0] result_a [N_INST];
  logic        bal_a    [N_INST];
  logic        eq_a     [N_INST];
  logic        busy_a   [N_INST];
  logic        amode_a  [N_INST];
  logic [4:0]  an1_a    [N_INST];
  logic [4:0]  an2_a    [N_INST];
  logic [5:0]  aop_a    [N_INST];
  logic        arst_a   [N_INST];
  logic [31:0] aout_a   [N_INST];
  logic        abal_a   [N_INST];
  logic        aeq_a    [N_INST];
  dbg_t        dbg_a    [N_INST];

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic last_m [N_INST];

  // ALU behaviour as seen by the scheduler: {balance, equality, output_num}.
  function automatic logic [33:0] alu_fn(input logic m, input logic [4:0] a,
                                         input logic [4:0] b, input logic [5:0] op);
    logic [9:0] p;
    p = {5'b0, a} * {5'b0, b};
    return {^{a, b, op}, (a == b), m, 3'b000, op, 2'b00, a, b, p};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 5);
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int L = (g == 0) ? 3 : ((g == 1) ? 1 : 5);
    logic [33:0] pipe [16];
    logic [33:0] alu_o;

    always @(posedge Clk) begin
      pipe[0] <= alu_fn(amode_a[g], an1_a[g], an2_a[g], aop_a[g]);
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end

    assign alu_o = (L == 1) ? alu_fn(amode_a[g], an1_a[g], an2_a[g], aop_a[g])
                            : pipe[(L >= 2) ? L - 2 : 0];
    assign {abal_a[g], aeq_a[g], aout_a[g]} = alu_o;

    alu_req_scheduler #(.RESULT_LAT(L), .CNT_W(4)) u_dut (
      .Clk               (Clk),
      .reset             (reset),
      .req               (req_a[g]),
      .mode_in           (mode_a[g]),
      .num1_in           (num1_a[g]),
      .num2_in           (num2_a[g]),
      .op_in             (op_a[g]),
      .ack               (ack_a[g]),
      .result            (result_a[g]),
      .res_balance       (bal_a[g]),
      .res_equality      (eq_a[g]),
      .busy              (busy_a[g]),
      .alu_mode          (amode_a[g]),
      .alu_number1       (an1_a[g]),
      .alu_number2       (an2_a[g]),
      .alu_operator_mode (aop_a[g]),
      .alu_reset         (arst_a[g]),
      .alu_output_num    (aout_a[g]),
      .alu_balance       (abal_a[g]),
      .alu_equality      (aeq_a[g]),
      .dbg               (dbg_a[g])
    );
  end

  // Monitor: every ack pulse must match the oldest expected response.
  logic [EW-1:0] mon_got, mon_exp;
  always @(negedge Clk) begin
    for (int k = 0; k < N_INST; k++) begin
      if (ack_a[k] != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack inst=%0d ack=%b required=none", k, ack_a[k]);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {2'(k), ack_a[k], bal_a[k], eq_a[k], result_a[k]};
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL ack_response got=%h required=%h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  // Wait for requester id's ack; want_n edges from now; operands observed want_n-lat edges in.
  task automatic wait_ack(input int k, input int id, input int want_n, input bit scramble);
    int n;
    bit got;
    int lat;
    lat = lat_of(k);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge Clk);
      #1;
      n++;
      if (ack_a[k][id]) begin
        got = 1'b1;
        req_a[k][id] = 1'b0;
      end else begin
        if (n == want_n - lat) begin
          chk("alu_inputs", {amode_a[k], an1_a[k], an2_a[k], aop_a[k]},
              {mode_a[k][id], num1_a[k][5*id +: 5], num2_a[k][5*id +: 5], op_a[k][6*id +: 6]});
          chk("busy_wait", busy_a[k], 1);
        end
        if (scramble && n == want_n - lat + 1) begin
          num1_a[k][5*id +: 5] = ~num1_a[k][5*id +: 5];
          op_a[k][6*id +: 6]   = ~op_a[k][6*id +: 6];
        end
      end
    end
    chk("ack_latency", n, want_n);
  endtask

  task automatic do_txn(input int k, input logic [1:0] who, input bit scramble);
    int first, second, lat;
    logic [33:0] e;
    lat = lat_of(k);
    for (int i = 0; i < 2; i++) begin
      if (who[i]) begin
        mode_a[k][i]        = 1'($urandom_range(0, 1));
        num1_a[k][5*i +: 5] = 5'($urandom_range(0, 31));
        num2_a[k][5*i +: 5] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) num2_a[k][5*i +: 5] = num1_a[k][5*i +: 5];
        op_a[k][6*i +: 6]   = 6'($urandom_range(0, 63));
      end
    end
    if (who == 2'b11) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      first = 0;
`else
      first = last_m[k] ? 0 : 1;
`endif
      second = 1 - first;
      last_m[k] = second[0];
    end else begin
      first     = who[1] ? 1 : 0;
      second    = -1;
      last_m[k] = first[0];
    end
    e = alu_fn(mode_a[k][first], num1_a[k][5*first +: 5], num2_a[k][5*first +: 5],
               op_a[k][6*first +: 6]);
    exp_q.push_back({2'(k), 2'(1 << first), e});
    if (second >= 0) begin
      e = alu_fn(mode_a[k][second], num1_a[k][5*second +: 5], num2_a[k][5*second +: 5],
                 op_a[k][6*second +: 6]);
      exp_q.push_back({2'(k), 2'(1 << second), e});
    end
    req_a[k] = who;
    wait_ack(k, first, lat + 1, scramble);
    if (second >= 0) wait_ack(k, second, lat + 2, scramble);
    @(posedge Clk);
    #1;
    chk("ack_clear", ack_a[k], 0);
    chk("busy_idle", busy_a[k], 0);
    repeat ($urandom_range(0, 2)) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N_INST; k++) begin
      req_a[k]  = '0;
      mode_a[k] = '0;
      num1_a[k] = '0;
      num2_a[k] = '0;
      op_a[k]   = '0;
      last_m[k] = 1'b1;
    end
    #23;
    for (int k = 0; k < N_INST; k++) begin
      chk("rst_ack", ack_a[k], 0);
      chk("rst_result", result_a[k], 0);
      chk("rst_flags", {bal_a[k], eq_a[k], busy_a[k]}, 0);
      chk("rst_alu_data", {amode_a[k], an1_a[k], an2_a[k], aop_a[k]}, 0);
      chk("rst_alu_reset", arst_a[k], 1);
      chk("rst_state", dbg_a[k].state, IDLE);
    end
    @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("alu_reset_release", arst_a[0], 0);

    do_txn(0, 2'b01, 1'b0);
    do_txn(0, 2'b11, 1'b0);
    do_txn(0, 2'b11, 1'b0);
    do_txn(0, 2'b10, 1'b1);
    for (int t = 0; t < 40; t++) do_txn(0, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    for (int t = 0; t < 8; t++)  do_txn(1, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    for (int t = 0; t < 8; t++)  do_txn(2, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));

    // Abort an operation mid-WAIT: no ack may follow.
    mode_a[0][1]   = 1'b0;
    num1_a[0][9:5] = 5'd9;
    num2_a[0][9:5] = 5'd4;
    op_a[0][11:6]  = 6'd3;
    req_a[0]       = 2'b10;
    @(posedge Clk);
    #1;
    chk("abort_alu_number1", an1_a[0], 9);
    @(posedge Clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_result", result_a[0], 0);
    chk("abort_alu_reset", arst_a[0], 1);
    chk("abort_busy", busy_a[0], 0);
    chk("abort_alu_number1_clr", an1_a[0], 0);
    chk("abort_ack", ack_a[0], 0);
    req_a[0] = 2'b00;
    for (int k = 0; k < N_INST; k++) last_m[k] = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    chk("abort_result_hold", result_a[0], 0);
    do_txn(0, 2'b11, 1'b0);
    do_txn(0, 2'b01, 1'b0);

    repeat (4) @(posedge Clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
